// File: rtl/cnt_run_sched.sv
// cnt_run_sched: shared-counter run scheduler.
//
// Up to NREQ requesters ask for a counting run of a programmed length on one
// shared CW-bit step counter. The block picks a requester with a round-robin
// arbiter, loads and sequences the counter, and then sends a one-cycle
// completion pulse back to the requester that held the grant.
//
// Parameters:
//   NREQ - number of requesters (2..16)
//   CW   - counter width
//   LW   - per-requester run-length field width (must not exceed CW)
//
// Ports:
//   CLK     in   clock, rising edge
//   RST     in   asynchronous reset, active-low
//   req     in   [NREQ]     per-requester run request (level)
//   len     in   [NREQ*LW]  run lengths; requester i uses len[i*LW +: LW]
//   abort   in   ends the current run early (honoured only while counting)
//   gnt     out  [NREQ]     one-hot grant, held for the whole run
//   busy    out  high while a run is loading, counting or completing
//   cnt     out  [CW]       shared counter value
//   done    out  [NREQ]     one-cycle completion pulse to the granted requester
//   aborted out  one-cycle pulse, coincident with done, for an aborted run
//
// Optional build macro CNT_RUN_SCHED_STATS_EN adds:
//   grant_total out [CW]  number of runs started, wraps
//   abort_total out [16]  number of aborted runs, saturates at 0xFFFF
module cnt_run_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 32,
  parameter int LW   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*LW-1:0] len,
  input  logic              abort,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [CW-1:0]     cnt,
  output logic [NREQ-1:0]   done,
  output logic              aborted
`ifdef CNT_RUN_SCHED_STATS_EN
  ,
  output logic [CW-1:0]     grant_total,
  output logic [15:0]       abort_total
`endif
);

  localparam int PW = $clog2(NREQ);

  // The counter must be able to reach the largest run length without wrapping.
  generate
    if (LW > CW) begin : g_lwTooWide
      $error("cnt_run_sched: LW must not exceed CW");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_nreqRange
      $error("cnt_run_sched: NREQ must be in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [NREQ-1:0] r_gnt;
  logic [PW-1:0]   r_gntIdx;
  logic [PW-1:0]   r_ptr;
  logic [LW-1:0]   r_runLen;
  logic [CW-1:0]   r_cnt;
  logic            r_abortFlag;

  logic            w_found;
  logic [PW-1:0]   w_selIdx;
  logic [NREQ-1:0] w_selOneHot;
  logic [LW-1:0]   w_selLen;
  logic            w_terminal;
  int              w_scan;

  // Round-robin pick: the first set req bit scanning upward from r_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_selIdx = '0;
    w_scan   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_scan = int'(r_ptr) + i;
      if (w_scan >= NREQ) w_scan = w_scan - NREQ;
      if (!w_found && req[w_scan]) begin
        w_found  = 1'b1;
        w_selIdx = PW'(w_scan);
      end
    end
  end

  // Decode the winner to one-hot and mux out its length field with constant slices.
  always_comb begin
    w_selOneHot = '0;
    w_selLen    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_selIdx == PW'(i)) begin
        w_selOneHot[i] = 1'b1;
        w_selLen       = len[i*LW +: LW];
      end
    end
  end

  // The run length is zero-extended. Zero-length runs skip RUN, so the minus one never underflows here.
  assign w_terminal = (r_cnt == (CW'(r_runLen) - CW'(1)));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Next-state logic. At the terminal count, abort changes nothing.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = LOAD;
      LOAD:    w_nextState = (r_runLen == '0) ? DONE : RUN;
      RUN:     if (w_terminal || abort) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode. The done and aborted pulses come straight from the DONE state.
  always_comb begin
    busy    = (r_state != IDLE);
    done    = '0;
    aborted = 1'b0;
    if (r_state == DONE) begin
      done    = r_gnt;
      aborted = r_abortFlag;
    end
  end

  assign gnt = r_gnt;
  assign cnt = r_cnt;

  // Run datapath: grant capture, counter sequencing and pointer advance.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_gnt       <= '0;
      r_gntIdx    <= '0;
      r_ptr       <= '0;
      r_runLen    <= '0;
      r_cnt       <= '0;
      r_abortFlag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt       <= w_selOneHot;
            r_gntIdx    <= w_selIdx;
            r_runLen    <= w_selLen;
            r_abortFlag <= 1'b0;
          end
        end
        LOAD: r_cnt <= '0;
        RUN: begin
          if (!w_terminal) begin
            if (abort) r_abortFlag <= 1'b1;
            else       r_cnt       <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_gnt <= '0;
          r_ptr <= (r_gntIdx == PW'(NREQ - 1)) ? '0 : r_gntIdx + PW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CNT_RUN_SCHED_STATS_EN
  logic [CW-1:0] r_grantTotal;
  logic [15:0]   r_abortTotal;

  // Statistics. One LOAD cycle per run, so counting LOAD cycles counts run starts.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_grantTotal <= '0;
      r_abortTotal <= '0;
    end else begin
      if (r_state == LOAD) r_grantTotal <= r_grantTotal + CW'(1);
      if (aborted && (r_abortTotal != 16'hFFFF)) r_abortTotal <= r_abortTotal + 16'd1;
    end
  end

  assign grant_total = r_grantTotal;
  assign abort_total = r_abortTotal;
`endif

endmodule

// File: tb/tb_cnt_run_sched.sv
// Directed self-checking bench for cnt_run_sched (default build, NREQ=4, CW=32, LW=8).
// Each run's expected completion is queued when the run is requested.
// It is popped and compared when the DUT shows its done pulse.
module tb_cnt_run_sched;

  localparam int NREQ = 4;
  localparam int CW   = 32;
  localparam int LW   = 8;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*LW-1:0] len;
  logic              abort;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [CW-1:0]     cnt;
  logic [NREQ-1:0]   done;
  logic              aborted;

  typedef struct packed {
    logic [NREQ-1:0] doneV;
    logic            abortedV;
    logic [CW-1:0]   cntV;
  } expEntry_t;

  expEntry_t sb[$];
  int passCount  = 0;
  int totalCount = 0;
  logic [NREQ*LW-1:0] lenV;

  cnt_run_sched #(.NREQ(NREQ), .CW(CW), .LW(LW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .len     (len),
    .abort   (abort),
    .gnt     (gnt),
    .busy    (busy),
    .cnt     (cnt),
    .done    (done),
    .aborted (aborted)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Overall time limit so the run always ends, even if the DUT misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock, then sample 1 unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] reqV, input logic [NREQ*LW-1:0] lenIn);
    req = reqV;
    len = lenIn;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Follow one run, starting from an IDLE cycle in which req is already driven.
  // abortAt < 0 means no abort. dropReq releases req right after the grant.
  task automatic observeRun(input int idx, input int runLen, input int abortAt, input bit dropReq);
    expEntry_t e;
    expEntry_t got;
    bit        expAb;
    int        c;
    expAb      = (abortAt >= 0) && (abortAt < runLen - 1);
    e.doneV    = NREQ'(1) << idx;
    e.abortedV = expAb;
    e.cntV     = (runLen == 0) ? '0 : (expAb ? CW'(abortAt) : CW'(runLen - 1));
    sb.push_back(e);

    tick();
    checkOutput("gntAfterSample", 64'(gnt), 64'(e.doneV));
    checkOutput("busyAfterSample", 64'(busy), 64'd1);
    if (dropReq) req = '0;

    tick();
    checkOutput("cntAfterLoad", 64'(cnt), 64'd0);

    c = 0;
    if (runLen > 0) begin
      for (int n = 0; n < runLen; n++) begin
        if (c == abortAt) abort = 1'b1;
        tick();
        abort = 1'b0;
        if (c == runLen - 1 || c == abortAt) break;
        c++;
        checkOutput("cntRun", 64'(cnt), 64'(c));
        checkOutput("noEarlyDone", 64'(done), 64'd0);
      end
    end

    checkOutput("donePresent", 64'(done != '0), 64'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      checkOutput("doneVec", 64'(done), 64'(got.doneV));
      checkOutput("abortedFlag", 64'(aborted), 64'(got.abortedV));
      checkOutput("cntAtDone", 64'(cnt), 64'(got.cntV));
    end else begin
      checkOutput("scoreboardEmpty", 64'(sb.size()), 64'd1);
    end

    tick();
    checkOutput("idleBusy", 64'(busy), 64'd0);
    checkOutput("idleGnt", 64'(gnt), 64'd0);
    checkOutput("idleDone", 64'(done), 64'd0);
  endtask

  initial begin
    RST   = 1'b0;
    abort = 1'b0;
    lenV  = '0;
    applyStimulus('0, lenV);

    // Reset state.
    tick();
    tick();
    checkOutput("rstGnt", 64'(gnt), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstCnt", 64'(cnt), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstAborted", 64'(aborted), 64'd0);
    RST = 1'b1;
    tick();
    checkOutput("idleNoReq", 64'(busy), 64'd0);

    // Single request on requester 1, len 5. req is dropped mid-run and the run still completes. ptr becomes 2.
    lenV[1*LW +: LW] = 8'd5;
    applyStimulus(4'b0010, lenV);
    observeRun(1, 5, -1, 1'b1);

    // ptr=2 must pick requester 2 over requester 0. Then ptr=3 wraps to requester 0.
    lenV[0*LW +: LW] = 8'd1;
    lenV[2*LW +: LW] = 8'd1;
    applyStimulus(4'b0101, lenV);
    observeRun(2, 1, -1, 1'b0);
    observeRun(0, 1, -1, 1'b1);

    // Zero-length run: LOAD then DONE directly, cnt 0.
    lenV[0*LW +: LW] = 8'd0;
    applyStimulus(4'b0001, lenV);
    observeRun(0, 0, -1, 1'b1);

    // Round-robin with all four held, len 2 each. ptr is 1 here, so the order is 1,2,3,0,1.
    for (int i = 0; i < NREQ; i++) lenV[i*LW +: LW] = 8'd2;
    applyStimulus(4'b1111, lenV);
    observeRun(1, 2, -1, 1'b0);
    observeRun(2, 2, -1, 1'b0);
    observeRun(3, 2, -1, 1'b0);
    observeRun(0, 2, -1, 1'b0);
    observeRun(1, 2, -1, 1'b1);

    // Abort at cnt 10 of a 100-cycle run on requester 0 (ptr 2, only requester 0 pending).
    lenV[0*LW +: LW] = 8'd100;
    applyStimulus(4'b0001, lenV);
    observeRun(0, 100, 10, 1'b1);

    // Abort on the terminal count counts as a normal completion. Requester 2, len 3. ptr becomes 3.
    lenV[2*LW +: LW] = 8'd3;
    applyStimulus(4'b0100, lenV);
    observeRun(2, 3, 2, 1'b1);

    // Asynchronous reset mid-run at cnt 7. The pending requesters 1 and 3 must restart from ptr 0.
    lenV[3*LW +: LW] = 8'd20;
    lenV[1*LW +: LW] = 8'd2;
    applyStimulus(4'b1000, lenV);
    tick();
    checkOutput("gntBeforeReset", 64'(gnt), 64'b1000);
    applyStimulus(4'b1010, lenV);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("cntBeforeReset", 64'(cnt), 64'd7);
    #2 RST = 1'b0;
    #1;
    checkOutput("asyncRstGnt", 64'(gnt), 64'd0);
    checkOutput("asyncRstBusy", 64'(busy), 64'd0);
    checkOutput("asyncRstCnt", 64'(cnt), 64'd0);
    checkOutput("asyncRstDone", 64'(done), 64'd0);
    tick();
    tick();
    checkOutput("heldRstDone", 64'(done), 64'd0);
    RST = 1'b1;
    observeRun(1, 2, -1, 1'b1);

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
